pc_ring: RTL and testbench

PC_RING -- requirements
Module: pc_ring

---
 rtl/lc3b_types.sv | 7 +
 rtl/pc_ring_cam.sv | 27 ++
 rtl/pc_ring.sv | 94 +++++++++
 tb/tb_pc_ring.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the PC history ring.
package lc3b_types;

    // Native machine word; sets the default width of every stored PC.
    typedef logic [15:0] lc3b_word;

endpackage : lc3b_types

// File: rtl/pc_ring_cam.sv
// Content-addressable match over the ring entries with lowest-index priority.
module pc_ring_cam #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] entries,
    input  logic [DEPTH-1:0]            valid,
    input  logic [WIDTH-1:0]            key,
    output logic                        match,
    output logic [IDXW-1:0]             index
);

    // Scan from the top down so the lowest matching index is the one that sticks.
    always_comb begin
        // NOTE: both outputs get a default before the loop, so no path leaves them unassigned and no latch is inferred.
        match = 1'b0;
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && entries[i] == key) begin
                match = 1'b1;
                index = IDXW'(i);
            end
        end
    end

endmodule : pc_ring_cam

// File: rtl/pc_ring.sv
// Circular history of recent PCs with CAM lookup, duplicate suppression and flush.
module pc_ring
    import lc3b_types::*;
#(
    parameter int WIDTH = $bits(lc3b_word),
    parameter int DEPTH = 8,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] datain,
    input  logic             flush,
    input  logic [WIDTH-1:0] lookup_addr,
    output logic             hit,
    output logic [IDXW-1:0]  hit_index,
    input  logic [IDXW-1:0]  rd_index,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] last,
    output logic [IDXW:0]    count,
    output logic             full,
    output logic             dup
);

    localparam logic [IDXW:0] COUNT_MAX = (IDXW + 1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [DEPTH-1:0]            valid;
    logic [IDXW-1:0]             wr_ptr;

    logic                        dup_hit;
    logic [IDXW-1:0]             dup_index;
    logic                        push_ok;

    // Lookup port: matches the externally supplied address.
    pc_ring_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) u_cam_lookup (
        .entries (mem),
        .valid   (valid),
        .key     (lookup_addr),
        .match   (hit),
        .index   (hit_index)
    );

    // Duplicate detector: matches the incoming PC against pre-edge contents.
    pc_ring_cam #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) u_cam_dup (
        .entries (mem),
        .valid   (valid),
        .key     (datain),
        .match   (dup_hit),
        .index   (dup_index)
    );

    // The matching slot of a duplicate is not needed, only the fact of a match.
    logic unused_dup_index;
    assign unused_dup_index = ^dup_index;

    assign push_ok = write && !flush && !reset && !dup_hit;

    // Read-side views are gated by the valid bits so stale storage stays hidden.
    assign rd_valid = valid[rd_index];
    assign rd_data  = valid[rd_index] ? mem[rd_index] : '0;
    assign last     = (count != '0) ? mem[wr_ptr - IDXW'(1)] : '0;
    assign full     = (count == COUNT_MAX);

    // Payload storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately left out of reset; visibility is controlled entirely by the valid bits, so clearing it would only add reset fan-out.
        if (push_ok) begin
            mem[wr_ptr] <= datain;
        end
    end

    // Control state: valid bits, write pointer, occupancy and duplicate pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset || flush) begin
            valid  <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dup    <= 1'b0;
        end else begin
            dup <= write && dup_hit;
            if (push_ok) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + IDXW'(1);
                if (count != COUNT_MAX) begin
                    count <= count + (IDXW + 1)'(1);
                end
            end
        end
    end

endmodule : pc_ring

// File: tb/tb_pc_ring.sv
// Directed self-checking bench for pc_ring at DEPTH=4.
module tb_pc_ring;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int IDXW  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             write = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] lookup_addr = '0;
    logic             hit;
    logic [IDXW-1:0]  hit_index;
    logic [IDXW-1:0]  rd_index = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] last;
    logic [IDXW:0]    count;
    logic             full;
    logic             dup;

    int errors = 0;
    int checks = 0;

    pc_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDXW(IDXW)) dut (
        .clk         (clk),
        .reset       (reset),
        .write       (write),
        .datain      (datain),
        .flush       (flush),
        .lookup_addr (lookup_addr),
        .hit         (hit),
        .hit_index   (hit_index),
        .rd_index    (rd_index),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .last        (last),
        .count       (count),
        .full        (full),
        .dup         (dup)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] pc);
        write  = 1'b1;
        datain = pc;
        tick();
        write  = 1'b0;
    endtask

    task automatic test_reset();
        lookup_addr = 16'h0000;
        rd_index    = 2'd0;
        datain      = 16'h0000;
        do_reset();
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit); end
        checks++; if (hit_index !== 2'd0) begin errors++; $display("FAIL reset_hit_index: got %0d want 0", hit_index); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (last !== 16'h0000) begin errors++; $display("FAIL reset_last: got %h want 0000", last); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (dup !== 1'b0) begin errors++; $display("FAIL reset_dup: got %b want 0", dup); end
    endtask

    task automatic test_fill();
        do_reset();
        push(16'h1000);
        push(16'h1002);
        push(16'h1004);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fill_count: got %0d want 3", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", full); end
        checks++; if (last !== 16'h1004) begin errors++; $display("FAIL fill_last: got %h want 1004", last); end
        rd_index = 2'd2; #1;
        checks++; if (rd_data !== 16'h1004) begin errors++; $display("FAIL fill_rd2_data: got %h want 1004", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL fill_rd2_valid: got %b want 1", rd_valid); end
        rd_index = 2'd3; #1;
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL fill_rd3_data: got %h want 0000", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL fill_rd3_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(16'h1000 + 16'(2 * i));
        end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count: got %0d want 4", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %b want 1", full); end
        checks++; if (last !== 16'h1008) begin errors++; $display("FAIL wrap_last: got %h want 1008", last); end
        rd_index = 2'd0; #1;
        checks++; if (rd_data !== 16'h1008) begin errors++; $display("FAIL wrap_entry0: got %h want 1008", rd_data); end
        lookup_addr = 16'h1000; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wrap_lookup_evicted: got %b want 0", hit); end
        lookup_addr = 16'h1008; #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL wrap_lookup_hit: got %b want 1", hit); end
        checks++; if (hit_index !== 2'd0) begin errors++; $display("FAIL wrap_lookup_index: got %0d want 0", hit_index); end
        lookup_addr = 16'h1006; #1;
        checks++; if (hit_index !== 2'd3) begin errors++; $display("FAIL wrap_lookup_index3: got %0d want 3", hit_index); end
        // Second overwrite on the full ring evicts slot 1 and keeps count at DEPTH.
        push(16'h100A);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap2_count: got %0d want 4", count); end
        checks++; if (last !== 16'h100A) begin errors++; $display("FAIL wrap2_last: got %h want 100a", last); end
        rd_index = 2'd1; #1;
        checks++; if (rd_data !== 16'h100A) begin errors++; $display("FAIL wrap2_entry1: got %h want 100a", rd_data); end
    endtask

    task automatic test_dup();
        do_reset();
        push(16'h2000);
        push(16'h2000);
        checks++; if (dup !== 1'b1) begin errors++; $display("FAIL dup_pulse: got %b want 1", dup); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup_count: got %0d want 1", count); end
        tick();
        checks++; if (dup !== 1'b0) begin errors++; $display("FAIL dup_clear: got %b want 0", dup); end
        // The suppressed push must not have advanced the write pointer.
        push(16'h2002);
        rd_index = 2'd1; #1;
        checks++; if (rd_data !== 16'h2002) begin errors++; $display("FAIL dup_ptr_hold: got %h want 2002", rd_data); end
        checks++; if (dup !== 1'b0) begin errors++; $display("FAIL dup_new_pc: got %b want 0", dup); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        lookup_addr = 16'h3000;
        write       = 1'b1;
        datain      = 16'h3000;
        #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL same_cycle_pre: got %b want 0", hit); end
        tick();
        write = 1'b0;
        #1;
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL same_cycle_post_hit: got %b want 1", hit); end
        checks++; if (hit_index !== 2'd0) begin errors++; $display("FAIL same_cycle_post_index: got %0d want 0", hit_index); end
    endtask

    task automatic test_flush();
        do_reset();
        push(16'h1000);
        push(16'h1002);
        push(16'h1004);
        flush  = 1'b1;
        write  = 1'b1;
        datain = 16'h4000;
        tick();
        flush = 1'b0;
        write = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (dup !== 1'b0) begin errors++; $display("FAIL flush_dup: got %b want 0", dup); end
        checks++; if (last !== 16'h0000) begin errors++; $display("FAIL flush_last: got %h want 0000", last); end
        lookup_addr = 16'h4000; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_hit_dropped: got %b want 0", hit); end
        lookup_addr = 16'h1002; #1;
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_hit_stale: got %b want 0", hit); end
        // Stale storage in slot 1 must not count as a duplicate; the push lands in slot 0.
        push(16'h1002);
        checks++; if (dup !== 1'b0) begin errors++; $display("FAIL flush_stale_dup: got %b want 0", dup); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_repush_count: got %0d want 1", count); end
        rd_index = 2'd0; #1;
        checks++; if (rd_data !== 16'h1002) begin errors++; $display("FAIL flush_repush_slot0: got %h want 1002", rd_data); end
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(16'h6000 + 16'(2 * i));
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL rfull_pre_full: got %b want 1", full); end
        reset  = 1'b1;
        write  = 1'b1;
        datain = 16'h6008;
        tick();
        reset = 1'b0;
        write = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rfull_count: got %0d want 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rfull_full: got %b want 0", full); end
        push(16'h5000);
        checks++; if (last !== 16'h5000) begin errors++; $display("FAIL rfull_last: got %h want 5000", last); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL rfull_count1: got %0d want 1", count); end
        rd_index = 2'd0; #1;
        checks++; if (rd_data !== 16'h5000) begin errors++; $display("FAIL rfull_slot0_data: got %h want 5000", rd_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rfull_slot0_valid: got %b want 1", rd_valid); end
        rd_index = 2'd1; #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rfull_slot1_valid: got %b want 0", rd_valid); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_dup();
        test_same_cycle();
        test_flush();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_ring
